// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU using 32-step restoring division; writes the result back via wen/waddr/wdata.
// Latency: 33 cycles from accept to the wen cycle; with DIV_UNIT_EARLY_OUT_EN, divide-by-zero and signed overflow finish 1 cycle after accept.
// Backpressure: in_ready is high only in IDLE with no flush; flush or reset_n cancels the operation in flight with no write-back.
module div_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [4:0]  rd,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        wen,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic        sd_q, sd_d, sv_q, sv_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        signed_op;
    logic [31:0] abs_dvd, abs_dvs;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] rem_step, quo_step, q_fix, r_fix, result;

    assign in_ready = (state_q == IDLE) && !flush;
    assign busy     = (state_q != IDLE);
    assign wen      = (state_q == DONE) && !flush;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;

    // quo_q starts as the dividend magnitude and fills with quotient bits as its MSBs shift out
    always_comb begin
        signed_op = !op[0];
        abs_dvd   = (signed_op && dividend[31]) ? -dividend : dividend;
        abs_dvs   = (signed_op && divisor[31])  ? -divisor  : divisor;
        shifted   = {rem_q, quo_q[31]};
        ge        = (shifted >= {1'b0, dvs_q});
        rem_step  = ge ? 32'(shifted - {1'b0, dvs_q}) : shifted[31:0];
        quo_step  = {quo_q[30:0], ge};
        q_fix     = (!op_q[0] && (sd_q != sv_q) && (dvs_q != 32'd0)) ? -quo_step : quo_step;
        r_fix     = (!op_q[0] && sd_q) ? -rem_step : rem_step;
        result    = op_q[1] ? r_fix : q_fix;
    end

`ifdef DIV_UNIT_EARLY_OUT_EN
    logic        eo_hit;
    logic [31:0] eo_result;

    always_comb begin
        eo_hit    = (divisor == 32'd0) ||
                    (signed_op && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF);
        eo_result = (divisor == 32'd0) ? (op[1] ? dividend : 32'hFFFF_FFFF)
                                       : (op[1] ? 32'd0 : 32'h8000_0000);
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        sd_d    = sd_q;
        sv_d    = sv_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_d    = op;
                        rd_d    = rd;
                        sd_d    = dividend[31];
                        sv_d    = divisor[31];
                        dvs_d   = abs_dvs;
                        quo_d   = abs_dvd;
                        rem_d   = 32'd0;
                        cnt_d   = 5'd0;
                        state_d = CALC;
`ifdef DIV_UNIT_EARLY_OUT_EN
                        if (eo_hit) begin
                            state_d = DONE;
                            waddr_d = rd;
                            wdata_d = eo_result;
                        end
`endif
                    end
                end
                CALC: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = DONE;
                        waddr_d = rd_q;
                        wdata_d = result;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            rd_q    <= 5'd0;
            sd_q    <= 1'b0;
            sv_q    <= 1'b0;
            dvs_q   <= 32'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            sd_q    <= sd_d;
            sv_q    <= sv_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: arithmetic reference model with per-cycle output compare, directed corner cases, flush, reset and random traffic.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'd0;
    logic [4:0]  rd = 5'd0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int n_vec = 0;
    int n_bad = 0;

    div_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rd       (rd),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // RV32M semantics straight from the ISA rules
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        logic [31:0] r;
        sa = a;
        sb = b;
        case (o)
            2'b00: if (b == 0) r = 32'hFFFF_FFFF;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                   else r = sa / sb;
            2'b01: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: if (b == 0) r = a;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                   else r = sa % sb;
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // edges from accept to the wen cycle
    function automatic int lat_of(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int l;
        l = 32;
`ifdef DIV_UNIT_EARLY_OUT_EN
        if (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) l = 0;
`else
        if (o == 2'b11 && a == 32'd0 && b == 32'd0) l = 32;
`endif
        return l;
    endfunction

    // reference model: one operation in flight, edges counted since accept
    bit          m_busy = 1'b0;
    int          m_k = 0;
    int          m_lat = 0;
    logic [31:0] m_res = 32'd0;
    logic [4:0]  m_rd = 5'd0;
    logic [4:0]  e_waddr = 5'd0;
    logic [31:0] e_wdata = 32'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  <= 1'b0;
            m_k     <= 0;
            m_lat   <= 0;
            e_waddr <= 5'd0;
            e_wdata <= 32'd0;
        end else if (m_busy) begin
            if (flush || m_k == m_lat) begin
                m_busy <= 1'b0;
            end else begin
                m_k <= m_k + 1;
                if (m_k + 1 == m_lat) begin
                    e_waddr <= m_rd;
                    e_wdata <= m_res;
                end
            end
        end else if (in_valid && !flush) begin
            m_busy <= 1'b1;
            m_k    <= 0;
            m_lat  <= lat_of(op, dividend, divisor);
            m_res  <= ref_res(op, dividend, divisor);
            m_rd   <= rd;
            if (lat_of(op, dividend, divisor) == 0) begin
                e_waddr <= rd;
                e_wdata <= ref_res(op, dividend, divisor);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy && !flush});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("wen", {31'd0, wen}, {31'd0, m_busy && m_k == m_lat && !flush});
        chk("waddr", {27'd0, waddr}, {27'd0, e_waddr});
        chk("wdata", wdata, e_wdata);
    end

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = $urandom_range(0, 200);
            5: v = -$urandom_range(1, 200);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [4:0] r, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_d, input string nm);
        int c;
        wait_idle();
        @(negedge clk);
        op = o; rd = r; dividend = a; divisor = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op = 2'($urandom); rd = 5'($urandom); dividend = $urandom; divisor = $urandom;
        c = 1;
        #1;
        while (!wen && c < 40) begin
            @(negedge clk);
            c++;
            #1;
        end
        chk({nm, "_wen"}, {31'd0, wen}, 32'd1);
        chk({nm, "_lat"}, c, lat_of(o, a, b) + 1);
        chk({nm, "_waddr"}, {27'd0, waddr}, {27'd0, r});
        chk({nm, "_wdata"}, wdata, exp_d);
    endtask

    initial begin
        int wens;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wen", {31'd0, wen}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_wdata", wdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        chk("model_divu", ref_res(2'b01, 32'd100, 32'd7), 32'd14);
        chk("model_rem", ref_res(2'b10, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFFE);
        chk("model_rem_neg_dvs", ref_res(2'b10, 32'd100, 32'hFFFF_FFF9), 32'd2);

        run_op(2'b01, 5'd5,  32'd100,         32'd7,          32'd14,          "divu_100_7");
        run_op(2'b11, 5'd6,  32'd100,         32'd7,          32'd2,           "remu_100_7");
        run_op(2'b00, 5'd7,  32'hFFFF_FF9C,   32'd7,          32'hFFFF_FFF2,   "div_m100_7");
        run_op(2'b10, 5'd8,  32'hFFFF_FF9C,   32'd7,          32'hFFFF_FFFE,   "rem_m100_7");
        run_op(2'b10, 5'd9,  32'd100,         32'hFFFF_FFF9,  32'd2,           "rem_100_m7");
        run_op(2'b00, 5'd10, 32'hFFFF_FF9C,   32'd0,          32'hFFFF_FFFF,   "div_by0");
        run_op(2'b10, 5'd11, 32'hFFFF_FF9C,   32'd0,          32'hFFFF_FF9C,   "rem_by0");
        run_op(2'b01, 5'd12, 32'd12345,       32'd0,          32'hFFFF_FFFF,   "divu_by0");
        run_op(2'b00, 5'd13, 32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,   "div_ovf");
        run_op(2'b10, 5'd14, 32'h8000_0000,   32'hFFFF_FFFF,  32'd0,           "rem_ovf");
        run_op(2'b01, 5'd0,  32'd50,          32'd5,          32'd10,          "divu_rd0");

        // flush mid-calculation
        wait_idle();
        @(negedge clk);
        op = 2'b01; rd = 5'd17; dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_wen", {31'd0, wen}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        wens = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (wen) wens++;
        end
        chk("flush_no_wen", wens, 0);
        run_op(2'b01, 5'd3, 32'd9, 32'd3, 32'd3, "divu_9_3");

        // asynchronous reset mid-calculation
        wait_idle();
        @(negedge clk);
        op = 2'b01; rd = 5'd21; dividend = 32'hFFFF_FFFF; divisor = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_wen", {31'd0, wen}, 32'd0);
        chk("arst_waddr", {27'd0, waddr}, 32'd0);
        chk("arst_wdata", wdata, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        wens = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (wen) wens++;
        end
        chk("arst_no_wen", wens, 0);

        // in_valid held high across busy periods
        @(negedge clk);
        op = 2'b00; rd = 5'd25; dividend = 32'hFFFF_F000; divisor = 32'd37; in_valid = 1'b1;
        repeat (75) @(negedge clk);
        in_valid = 1'b0;
        wait_idle();

        // random traffic with corner-biased operands
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 149) == 0);
            op       = 2'($urandom);
            rd       = 5'($urandom);
            dividend = pick();
            divisor  = pick();
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
